tx_sweep_scheduler: RTL and testbench

// - Sequences transmit_beamformer through a steering-angle sweep: per period, fetches sin(|angle|) from an external sine ROM.
// - Holds sin_value/sign_bit stable for the whole period, gates the transducer drive for BURST_DURATION, then opens a listen window.
// - Sits between top-level control (start/stop, mode) and the beamformer and receive chain.

---
 rtl/tx_sweep_scheduler_if.sv | 46 ++++
 rtl/tx_sweep_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_tx_sweep_scheduler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_sweep_scheduler_if.sv
// -----------------------------------------------------------------------------
// tx_sweep_scheduler_if
// Purpose : bundles every non-clock, non-reset signal of tx_sweep_scheduler:
//           the control inputs, the sine-ROM bus, the beamformer drive and
//           the status outputs.
// Modports:
//   master - scheduler side (drives the ROM address and all *_out signals)
//   slave  - environment side (control, ROM data; observes the outputs)
// Signals :
//   start_in, stop_in, fixed_mode_in, fixed_idx_in      control
//   sin_addr_out / sin_data_in                          sine ROM bus
//   sin_value_out, sign_bit_out, angle_idx_out          beamformer steering
//   tx_enable_out, listen_out                           burst / receive gates
//   period_start_out, sweep_done_out, busy_out          status
// -----------------------------------------------------------------------------
interface tx_sweep_scheduler_if #(
  parameter int SIN_WIDTH = 17,
  parameter int IDX_WIDTH = 6
);
  logic                        start_in;
  logic                        stop_in;
  logic                        fixed_mode_in;
  logic signed [IDX_WIDTH:0]   fixed_idx_in;
  logic [IDX_WIDTH-1:0]        sin_addr_out;
  logic [SIN_WIDTH-1:0]        sin_data_in;
  logic [SIN_WIDTH-1:0]        sin_value_out;
  logic                        sign_bit_out;
  logic signed [IDX_WIDTH:0]   angle_idx_out;
  logic                        tx_enable_out;
  logic                        listen_out;
  logic                        period_start_out;
  logic                        sweep_done_out;
  logic                        busy_out;

  modport master (
    input  start_in, stop_in, fixed_mode_in, fixed_idx_in, sin_data_in,
    output sin_addr_out, sin_value_out, sign_bit_out, angle_idx_out,
           tx_enable_out, listen_out, period_start_out, sweep_done_out, busy_out
  );

  modport slave (
    output start_in, stop_in, fixed_mode_in, fixed_idx_in, sin_data_in,
    input  sin_addr_out, sin_value_out, sign_bit_out, angle_idx_out,
           tx_enable_out, listen_out, period_start_out, sweep_done_out, busy_out
  );
endinterface

// File: rtl/tx_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tx_sweep_scheduler
// Purpose : steps the transmit beamformer through a steering-angle sweep.
//           Each period: FETCH (ROM address = |idx|), LOAD (latch sine,
//           sign and index), BURST (tx_enable high), LISTEN (receive window).
//           The period is exactly PERIOD_DURATION clocks, FETCH to FETCH.
// Ports   :
//   clk_in  - system clock
//   rst_in  - synchronous, active-low reset
//   bus     - tx_sweep_scheduler_if.master (control, ROM bus, outputs)
// Config  : define PINGPONG_SWEEP_EN to make the sweep bounce between
//           -MAX_IDX and +MAX_IDX (sweep_done at both endpoints) instead of
//           wrapping from +MAX_IDX back to -MAX_IDX.
// All outputs are registered; there is no combinational input->output path.
// -----------------------------------------------------------------------------
module tx_sweep_scheduler #(
  parameter int PERIOD_DURATION = 16777216,
  parameter int BURST_DURATION  = 524288,
  parameter int SIN_WIDTH       = 17,
  parameter int MAX_IDX         = 18,
  parameter int IDX_WIDTH       = 6,
  parameter int CNT_WIDTH       = 25
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  tx_sweep_scheduler_if.master bus
);

  localparam logic signed [IDX_WIDTH:0] L_MAX = (IDX_WIDTH+1)'(MAX_IDX);
  localparam logic signed [IDX_WIDTH:0] L_ONE = (IDX_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] L_BURST_LAST  = CNT_WIDTH'(BURST_DURATION - 1);
  localparam logic [CNT_WIDTH-1:0] L_LISTEN_LAST = CNT_WIDTH'(PERIOD_DURATION - BURST_DURATION - 3);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_BURST, S_LISTEN
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic [CNT_WIDTH-1:0]        w_cnt_nxt;
  logic                        r_stop_pend;
  logic                        w_stop_req;
  logic                        w_done_nxt;
  logic                        w_endpoint;
  logic signed [IDX_WIDTH:0]   r_sweep_idx;   // sweep position for the next sweep-mode period
  logic signed [IDX_WIDTH:0]   r_cur_idx;     // index of the period in flight
  logic                        r_cur_fixed;
  logic signed [IDX_WIDTH:0]   w_fixed_clamped;
`ifdef PINGPONG_SWEEP_EN
  logic                        r_dir_up;
`endif

  logic [IDX_WIDTH-1:0]        r_sin_addr;
  logic [SIN_WIDTH-1:0]        r_sin_value;
  logic                        r_sign;
  logic signed [IDX_WIDTH:0]   r_angle;
  logic                        r_tx_en;
  logic                        r_listen;
  logic                        r_period_start;
  logic                        r_sweep_done;
  logic                        r_busy;

  // Out-of-range fixed indices saturate to +/-MAX_IDX, keeping their sign.
  function automatic logic signed [IDX_WIDTH:0] clamp_idx(input logic signed [IDX_WIDTH:0] v);
    if (v > L_MAX)       return L_MAX;
    else if (v < -L_MAX) return -L_MAX;
    else                 return v;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] mag_idx(input logic signed [IDX_WIDTH:0] v);
    logic signed [IDX_WIDTH:0] a;
    a = (v < 0) ? -v : v;
    return a[IDX_WIDTH-1:0];
  endfunction

  assign w_fixed_clamped = clamp_idx(bus.fixed_idx_in);
  // A stop arriving in the very last LISTEN cycle must still be honoured.
  assign w_stop_req      = r_stop_pend | bus.stop_in;

`ifdef PINGPONG_SWEEP_EN
  assign w_endpoint = (r_cur_idx == L_MAX) || (r_cur_idx == -L_MAX);
`else
  assign w_endpoint = (r_cur_idx == L_MAX);
`endif

  // Next state and the shared period counter (counts down in BURST and LISTEN).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE:   if (bus.start_in) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_state_nxt = S_BURST;
        w_cnt_nxt   = L_BURST_LAST;
      end
      S_BURST: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_LISTEN;
          w_cnt_nxt   = L_LISTEN_LAST;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_LISTEN: begin
        if (r_cnt == '0) w_state_nxt = w_stop_req ? S_IDLE : S_FETCH;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // sweep_done is raised during the final LISTEN cycle of an endpoint period.
  assign w_done_nxt = (w_state_nxt == S_LISTEN) && (w_cnt_nxt == '0) &&
                      !r_cur_fixed && w_endpoint;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_stop_pend    <= 1'b0;
      r_sweep_idx    <= -L_MAX;
      r_cur_idx      <= '0;
      r_cur_fixed    <= 1'b0;
`ifdef PINGPONG_SWEEP_EN
      r_dir_up       <= 1'b1;
`endif
      r_sin_addr     <= '0;
      r_sin_value    <= '0;
      r_sign         <= 1'b0;
      r_angle        <= '0;
      r_tx_en        <= 1'b0;
      r_listen       <= 1'b0;
      r_period_start <= 1'b0;
      r_sweep_done   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;

      // In IDLE a stop only counts when it comes with a start.
      if (w_state_nxt == S_IDLE)  r_stop_pend <= 1'b0;
      else if (r_state == S_IDLE) r_stop_pend <= bus.stop_in;
      else                        r_stop_pend <= w_stop_req;

      // Index selection happens on the edge into FETCH so that the ROM
      // address is valid throughout FETCH and data arrives in LOAD.
      if (w_state_nxt == S_FETCH) begin
        r_cur_fixed <= bus.fixed_mode_in;
        if (bus.fixed_mode_in) begin
          r_cur_idx  <= w_fixed_clamped;
          r_sin_addr <= mag_idx(w_fixed_clamped);
        end else begin
          r_cur_idx  <= r_sweep_idx;
          r_sin_addr <= mag_idx(r_sweep_idx);
`ifdef PINGPONG_SWEEP_EN
          if (r_dir_up) begin
            if (r_sweep_idx == L_MAX) begin
              r_sweep_idx <= r_sweep_idx - L_ONE;
              r_dir_up    <= 1'b0;
            end else begin
              r_sweep_idx <= r_sweep_idx + L_ONE;
            end
          end else begin
            if (r_sweep_idx == -L_MAX) begin
              r_sweep_idx <= r_sweep_idx + L_ONE;
              r_dir_up    <= 1'b1;
            end else begin
              r_sweep_idx <= r_sweep_idx - L_ONE;
            end
          end
`else
          r_sweep_idx <= (r_sweep_idx == L_MAX) ? -L_MAX : r_sweep_idx + L_ONE;
`endif
        end
      end

      if (r_state == S_LOAD) begin
        r_sin_value <= bus.sin_data_in;
        r_sign      <= (r_cur_idx < 0);
        r_angle     <= r_cur_idx;
      end

      r_tx_en        <= (w_state_nxt == S_BURST);
      r_listen       <= (w_state_nxt == S_LISTEN);
      r_period_start <= (r_state == S_LOAD);
      r_sweep_done   <= w_done_nxt;
      r_busy         <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.sin_addr_out     = r_sin_addr;
  assign bus.sin_value_out    = r_sin_value;
  assign bus.sign_bit_out     = r_sign;
  assign bus.angle_idx_out    = r_angle;
  assign bus.tx_enable_out    = r_tx_en;
  assign bus.listen_out       = r_listen;
  assign bus.period_start_out = r_period_start;
  assign bus.sweep_done_out   = r_sweep_done;
  assign bus.busy_out         = r_busy;

endmodule

// File: tb/tb_tx_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tx_sweep_scheduler
// Scoreboard bench: each session pushes the expected per-period records from
// a sweep reference model; a monitor pops one record on every
// period_start_out pulse and also checks burst/listen lengths, period spacing
// and sweep_done placement.
// -----------------------------------------------------------------------------
module tb_tx_sweep_scheduler;

  localparam int P   = 32;
  localparam int B   = 8;
  localparam int MAX = 2;
  localparam int LST = P - B - 2;

  typedef struct {
    int idx;
    int sin;
    int sign;
    int done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tx_sweep_scheduler_if #(.SIN_WIDTH(17), .IDX_WIDTH(6)) bus ();

  tx_sweep_scheduler #(
    .PERIOD_DURATION(P), .BURST_DURATION(B), .SIN_WIDTH(17),
    .MAX_IDX(MAX), .IDX_WIDTH(6), .CNT_WIDTH(25)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // Registered sine ROM: sin[k] = 1000*k, one cycle after the address.
  always @(posedge clk) bus.sin_data_in <= 17'(1000 * int'(bus.sin_addr_out));

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   m_pos = -MAX;
  int   m_dir = 1;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Reference model: one call per period, returns what that period must show.
  function automatic exp_t model_next(input bit fixed, input int fi);
    exp_t e;
    int   nxt;
    if (fixed) begin
      e.idx = (fi > MAX) ? MAX : ((fi < -MAX) ? -MAX : fi);
      e.done = 0;
    end else begin
      e.idx = m_pos;
`ifdef PINGPONG_SWEEP_EN
      e.done = (m_pos == MAX || m_pos == -MAX) ? 1 : 0;
      nxt = m_pos + m_dir;
      if (nxt > MAX || nxt < -MAX) begin
        m_dir = -m_dir;
        nxt   = m_pos + m_dir;
      end
`else
      e.done = (m_pos == MAX) ? 1 : 0;
      nxt = m_pos + 1;
      if (nxt > MAX) nxt = -MAX;
`endif
      m_pos = nxt;
    end
    e.sin  = 1000 * ((e.idx < 0) ? -e.idx : e.idx);
    e.sign = (e.idx < 0) ? 1 : 0;
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    int   cyc, tx_run, ls_run, last_ps, done_cyc;
    bit   prev_tx, prev_ls, busy_cont, cur_done, done_seen;
    exp_t e;
    cyc = 0; tx_run = 0; ls_run = 0; last_ps = -1; done_cyc = -1;
    prev_tx = 0; prev_ls = 0; busy_cont = 0; cur_done = 0; done_seen = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        tx_run = 0; ls_run = 0; last_ps = -1; prev_tx = 0; prev_ls = 0;
        busy_cont = 0; cur_done = 0; done_seen = 0;
        continue;
      end
      if (!bus.busy_out) busy_cont = 0;
      if (bus.period_start_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_period_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("angle_idx",  int'($signed(bus.angle_idx_out)), e.idx);
          chk("sign_bit",   int'(bus.sign_bit_out), e.sign);
          chk("sin_value",  int'(bus.sin_value_out), e.sin);
          chk("tx_at_start", int'(bus.tx_enable_out), 1);
          if (busy_cont && last_ps >= 0) chk("period_len", cyc - last_ps, P);
          cur_done  = e.done[0];
          done_seen = 0;
        end
        last_ps   = cyc;
        busy_cont = 1;
      end
      if (bus.tx_enable_out && bus.listen_out) chk("tx_listen_overlap", 1, 0);
      if (bus.sweep_done_out) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (bus.tx_enable_out) tx_run++;
      else if (prev_tx) begin
        chk("burst_len", tx_run, B);
        tx_run = 0;
      end
      if (bus.listen_out) ls_run++;
      else if (prev_ls) begin
        chk("listen_len", ls_run, LST);
        if (cur_done) chk("sweep_done_at_listen_end", (done_seen && done_cyc == cyc - 1) ? 1 : 0, 1);
        else          chk("sweep_done_absent", int'(done_seen), 0);
        ls_run = 0;
      end
      prev_tx = bus.tx_enable_out;
      prev_ls = bus.listen_out;
    end
  end

  // ---------------------------------------------------------------- driver
  // s = index of the edge that samples stop_in (0 = together with start).
  task automatic run_session(input int n, input bit fixed, input int fi, input int s);
    int   k, first_mag;
    exp_t e;
    first_mag = 0;
    bus.fixed_mode_in = fixed;
    bus.fixed_idx_in  = 7'(fi);
    for (int p = 0; p < n; p++) begin
      e = model_next(fixed, fi);
      if (p == 0) first_mag = (e.idx < 0) ? -e.idx : e.idx;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.stop_in  = (s == 0);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    chk("busy_after_start", int'(bus.busy_out), 1);
    chk("sin_addr_in_fetch", int'(bus.sin_addr_out), first_mag);
    k = 0;
    while (bus.busy_out && k < n * P + 2 * P) begin
      bus.stop_in = (k + 1 == s);
      @(posedge clk); #1;
      bus.stop_in = 1'b0;
      k++;
    end
    chk("session_cycles", k, n * P);
    repeat ($urandom_range(1, 4)) @(posedge clk);
  endtask

  task automatic reset_mid_burst();
    exp_t e;
    bus.fixed_mode_in = 1'b0;
    e = model_next(1'b0, 0);
    exp_q.push_back(e);
    @(negedge clk);
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("tx_before_reset", int'(bus.tx_enable_out), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_tx",     int'(bus.tx_enable_out), 0);
    chk("rst_mid_listen", int'(bus.listen_out), 0);
    chk("rst_mid_busy",   int'(bus.busy_out), 0);
    chk("rst_mid_angle",  int'($signed(bus.angle_idx_out)), 0);
    chk("rst_mid_sin",    int'(bus.sin_value_out), 0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_pos = -MAX;
    m_dir = 1;
    repeat (2) @(posedge clk);
  endtask

  initial begin : stim
    int n, s, fi;
    bit fixed;
    bus.start_in      = 1'b0;
    bus.stop_in       = 1'b0;
    bus.fixed_mode_in = 1'b0;
    bus.fixed_idx_in  = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_outputs", int'({bus.tx_enable_out, bus.listen_out, bus.period_start_out,
                                 bus.sweep_done_out, bus.sign_bit_out}), 0);
    chk("rst_hold_busy", int'(bus.busy_out), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy",     int'(bus.busy_out), 0);
    chk("post_rst_sin_addr", int'(bus.sin_addr_out), 0);
    chk("post_rst_sin_val",  int'(bus.sin_value_out), 0);
    chk("post_rst_angle",    int'($signed(bus.angle_idx_out)), 0);

    run_session(6, 1'b0, 0, 5 * P + 3);          // full sweep plus wrap
    run_session(2, 1'b0, 0, P + 2 + 3);          // stop in a burst
    run_session(1, 1'b0, 0, 0);                  // start and stop together
    run_session(2, 1'b0, 0, 2 * P);              // stop in last listen cycle
    run_session(3, 1'b1, -7, 2 * P + 10);        // fixed, clamped negative
    run_session(2, 1'b1, 40, P + 1);             // fixed, clamped positive
    run_session(1, 1'b1, 0, 0);                  // fixed index 0: sign 0
    run_session(2, 1'b1, 1, P + 20);             // fixed, in range

    for (int r = 0; r < 12; r++) begin
      n     = $urandom_range(1, 4);
      fixed = ($urandom_range(0, 2) == 0);
      fi    = int'($urandom_range(0, 127)) - 64;
      if (n == 1 && $urandom_range(0, 1) == 1) s = 0;
      else s = (n - 1) * P + 1 + int'($urandom_range(0, P - 1));
      run_session(n, fixed, fi, s);
    end

    reset_mid_burst();
    run_session(2, 1'b0, 0, 2 * P - 1);          // resumes at -MAX after reset

    repeat (3) @(posedge clk);
    chk("leftover_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
